// File: rtl/axi_bram_log_reader.sv
`default_nettype none
// ============================================================================
// Module   : axi_bram_log_reader
// Purpose  : Drains 96-bit log records from the BRAM read port and serialises
//            them into a 32-bit valid/ready word stream. Optional macro
//            AXI_BRAM_LOG_READER_TSDELTA_EN turns word 2 into a timestamp delta.
// Revision : 1.0 - initial release
// ============================================================================
module axi_bram_log_reader #(
    parameter int LOG_DATA_BITW = 96,
    parameter int NUM_WORDS     = 3,
    parameter int NUM_SER_BRAMS = 12,
    parameter int CNT_BITW      = 14,
    parameter int ADDR_BITW     = 16,
    parameter int RD_LAT        = 1
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RI,
    input  logic                     Start_SI,
    input  logic                     Abort_SI,
    input  logic [CNT_BITW-1:0]      NumEntries_DI,
    output logic                     Busy_SO,
    output logic                     Done_SO,
    output logic                     BramEn_SO,
    output logic [ADDR_BITW-1:0]     BramAddr_DO,
    input  logic [LOG_DATA_BITW-1:0] BramRd_DI,
    output logic                     OutValid_SO,
    input  logic                     OutReady_SI,
    output logic [31:0]              OutData_DO,
    output logic                     OutLast_SO
);

    localparam int                  c_MAX_ENTRIES = 1024 * NUM_SER_BRAMS;
    localparam logic [CNT_BITW-1:0] c_CAP         = CNT_BITW'(c_MAX_ENTRIES);
    localparam logic [CNT_BITW-1:0] c_ONE         = CNT_BITW'(1);
    localparam int                  c_PTR_W       = $clog2(NUM_WORDS + 1);
    localparam logic [c_PTR_W-1:0]  c_LAST_PTR    = c_PTR_W'(NUM_WORDS - 1);
    localparam logic [1:0]          c_LAT_END     = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                   r_state;
    logic [CNT_BITW-1:0]      r_idx;
    logic [CNT_BITW-1:0]      r_remaining;
    logic [c_PTR_W-1:0]       r_ptr;
    logic [1:0]               r_lat_cnt;
    logic [LOG_DATA_BITW-1:0] r_record;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_bram_en;
    logic [ADDR_BITW-1:0]     r_bram_addr;
    logic                     r_out_valid;
    logic [31:0]              r_out_data;
    logic                     r_out_last;

    logic                     w_xfer;
    logic                     w_last_rec;
    logic [CNT_BITW-1:0]      w_start_cnt;
    logic [CNT_BITW-1:0]      w_next_idx;
    logic [c_PTR_W-1:0]       w_ptr_next;
    logic [31:0]              w_ts_base;

    always_comb begin
        w_xfer      = r_out_valid && OutReady_SI;
        w_last_rec  = (r_remaining == c_ONE);
        w_start_cnt = (NumEntries_DI > c_CAP) ? c_CAP : NumEntries_DI;
        w_next_idx  = r_idx + c_ONE;
        w_ptr_next  = r_ptr + c_PTR_W'(1);
    end

`ifdef AXI_BRAM_LOG_READER_TSDELTA_EN
    logic [31:0] r_prev_ts;

    // Tracks the timestamp of the last record whose word 2 actually left.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_prev_ts <= '0;
        end else if (r_state == S_IDLE && Start_SI) begin
            r_prev_ts <= '0;
        end else if (r_state == S_STREAM && w_xfer && r_ptr == c_LAST_PTR) begin
            r_prev_ts <= r_record[LOG_DATA_BITW-1 -: 32];
        end
    end

    always_comb w_ts_base = r_prev_ts;
`else
    always_comb w_ts_base = '0;
`endif

    function automatic logic [ADDR_BITW-1:0] f_addr(input logic [CNT_BITW-1:0] idx);
        logic [ADDR_BITW-1:0] a;
        a               = '0;
        a[CNT_BITW+1:2] = idx;
        return a;
    endfunction

    // Word NUM_WORDS-1 is the timestamp; a zero base leaves it raw.
    function automatic logic [31:0] f_word(input logic [LOG_DATA_BITW-1:0] rec,
                                           input logic [c_PTR_W-1:0]       k,
                                           input logic [31:0]              base);
        logic [31:0] w;
        w = rec[32*k +: 32];
        if (k == c_LAST_PTR) begin
            w = w - base;
        end
        return w;
    endfunction

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_remaining <= '0;
            r_ptr       <= '0;
            r_lat_cnt   <= '0;
            r_record    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (r_state != S_IDLE && Abort_SI) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start_SI) begin
                        r_remaining <= w_start_cnt;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        if (w_start_cnt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_FETCH;
                            r_bram_en   <= 1'b1;
                            r_bram_addr <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    r_bram_en <= 1'b0;
                    r_lat_cnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat_cnt == c_LAT_END) begin
                        r_record    <= BramRd_DI;
                        r_ptr       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= f_word(BramRd_DI, '0, w_ts_base);
                        r_out_last  <= (NUM_WORDS == 1) && w_last_rec;
                        r_state     <= S_STREAM;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (r_ptr == c_LAST_PTR) begin
                            r_remaining <= r_remaining - c_ONE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (w_last_rec) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                // Index only moves when another record follows, so it stays in range.
                                r_idx       <= w_next_idx;
                                r_state     <= S_FETCH;
                                r_bram_en   <= 1'b1;
                                r_bram_addr <= f_addr(w_next_idx);
                            end
                        end else begin
                            r_ptr      <= w_ptr_next;
                            r_out_data <= f_word(r_record, w_ptr_next, w_ts_base);
                            r_out_last <= (w_ptr_next == c_LAST_PTR) && w_last_rec;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy_SO     = r_busy;
    assign Done_SO     = r_done;
    assign BramEn_SO   = r_bram_en;
    assign BramAddr_DO = r_bram_addr;
    assign OutValid_SO = r_out_valid;
    assign OutData_DO  = r_out_data;
    assign OutLast_SO  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_axi_bram_log_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_bram_log_reader
// Purpose  : Scoreboard bench for axi_bram_log_reader with a 1-cycle BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_bram_log_reader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic        Ready = 1'b1;
    logic [13:0] NumEntries = '0;
    logic        Busy, Done, BramEn, OutValid, OutLast;
    logic [15:0] BramAddr;
    logic [31:0] OutData;
    logic [95:0] rd_q = '0;

    logic [95:0] mem [0:12287];
    logic [32:0] exp_words [$];
    logic [15:0] exp_addrs [$];
    logic [32:0] mon_w;
    logic [15:0] mon_a;
    logic [15:0] last_addr = '0;
    int          n_err = 0;
    int          n_chk = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          rec_cnt = 0;
`ifdef AXI_BRAM_LOG_READER_TSDELTA_EN
    logic [31:0] tb_prev = '0;
`endif

    axi_bram_log_reader dut (
        .Clk_CI        (Clk),
        .Rst_RI        (Rst),
        .Start_SI      (Start),
        .Abort_SI      (Abort),
        .NumEntries_DI (NumEntries),
        .Busy_SO       (Busy),
        .Done_SO       (Done),
        .BramEn_SO     (BramEn),
        .BramAddr_DO   (BramAddr),
        .BramRd_DI     (rd_q),
        .OutValid_SO   (OutValid),
        .OutReady_SI   (Ready),
        .OutData_DO    (OutData),
        .OutLast_SO    (OutLast)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (BramEn) rd_q <= mem[BramAddr[15:2]];
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [95:0] act);
        n_chk++;
        n_err++;
        $display("FAIL %s: actual=%0h required=none", name, act);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a BRAM read or a word transfer.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (Done) done_cnt++;
            if (BramEn) begin
                if (exp_addrs.size() == 0) begin
                    flag("bram_addr_unexpected", BramAddr);
                end else begin
                    mon_a = exp_addrs.pop_front();
                    chk("bram_addr", BramAddr, mon_a);
                end
                last_addr = BramAddr;
                rec_cnt++;
            end
            if (OutValid && Ready) begin
                if (exp_words.size() == 0) begin
                    flag("word_unexpected", {OutLast, OutData});
                end else begin
                    mon_w = exp_words.pop_front();
                    chk("stream_word", {OutLast, OutData}, mon_w);
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input logic last);
        exp_words.push_back({last, d});
    endtask

    task automatic push_rec(input int i, input logic final_rec);
        logic [95:0] r;
        logic [31:0] w2;
        r = mem[i];
        w2 = r[95:64];
`ifdef AXI_BRAM_LOG_READER_TSDELTA_EN
        w2 = r[95:64] - tb_prev;
        tb_prev = r[95:64];
`endif
        exp_addrs.push_back(16'(i << 2));
        push_word(r[31:0], 1'b0);
        push_word(r[63:32], 1'b0);
        push_word(w2, final_rec);
    endtask

    task automatic clear_prev();
`ifdef AXI_BRAM_LOG_READER_TSDELTA_EN
        tb_prev = '0;
`endif
    endtask

    task automatic do_start(input logic [13:0] n);
        @(posedge Clk); #1;
        Start = 1'b1;
        NumEntries = n;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  k;
        logic seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < budget) begin
            if (Done) seen = 1'b1;
            else begin
                @(posedge Clk); #1;
                k++;
            end
        end
        chk("done_seen", seen, 1'b1);
        @(posedge Clk); #1;
    endtask

    task automatic wait_word(input logic [31:0] d, input int budget, output logic found);
        int k;
        k = 0;
        found = 1'b0;
        while (!found && k < budget) begin
            if (OutValid && OutData == d) found = 1'b1;
            else begin
                @(posedge Clk); #1;
                k++;
            end
        end
        if (!found) flag("wait_word_timeout", d);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},  Busy, 1'b0);
        chk({tag, "_done"},  Done, 1'b0);
        chk({tag, "_en"},    BramEn, 1'b0);
        chk({tag, "_addr"},  BramAddr, 16'h0);
        chk({tag, "_valid"}, OutValid, 1'b0);
        chk({tag, "_data"},  OutData, 32'h0);
        chk({tag, "_last"},  OutLast, 1'b0);
    endtask

    initial begin
        logic found;
        for (int i = 0; i < 12288; i++) begin
            mem[i] = {32'h0001_0000 + 32'(i), 32'h9000_0000 + 32'(i << 6), 32'h0000_0100 + 32'(i)};
        end
        mem[0] = {32'h0000_0010, 32'h8000_0000, 32'h0000_0305};
        mem[1] = {32'h0000_0020, 32'h8000_0040, 32'h0000_0006};

        repeat (3) @(posedge Clk);
        #1;
        chk_outputs_zero("reset");
        Rst = 1'b0;

        // Zero-length drain
        do_start(14'd0);
        chk("zero_done", Done, 1'b1);
        chk("zero_busy", Busy, 1'b1);
        chk("zero_valid", OutValid, 1'b0);
        exp_done++;
        @(posedge Clk); #1;
        chk("zero_done_drop", Done, 1'b0);
        chk("zero_busy_drop", Busy, 1'b0);
        chk("zero_done_count", done_cnt, exp_done);

        // Basic two-record drain
        exp_addrs.push_back(16'h0);
        exp_addrs.push_back(16'h4);
        push_word(32'h0000_0305, 1'b0);
        push_word(32'h8000_0000, 1'b0);
        push_word(32'h0000_0010, 1'b0);
        push_word(32'h0000_0006, 1'b0);
        push_word(32'h8000_0040, 1'b0);
`ifdef AXI_BRAM_LOG_READER_TSDELTA_EN
        push_word(32'h0000_0010, 1'b1);
`else
        push_word(32'h0000_0020, 1'b1);
`endif
        do_start(14'd2);
        wait_done(50);
        exp_done++;
        chk("basic_done_count", done_cnt, exp_done);
        chk("basic_words_left", exp_words.size(), 0);
        chk("basic_addrs_left", exp_addrs.size(), 0);

        // Backpressure during word 1
        clear_prev();
        push_rec(0, 1'b0);
        push_rec(1, 1'b1);
        do_start(14'd2);
        wait_word(32'h8000_0000, 50, found);
        Ready = 1'b0;
        repeat (5) begin
            @(posedge Clk); #1;
            chk("bp_valid", OutValid, 1'b1);
            chk("bp_data", OutData, 32'h8000_0000);
        end
        Ready = 1'b1;
        wait_done(50);
        exp_done++;
        chk("bp_done_count", done_cnt, exp_done);
        chk("bp_words_left", exp_words.size(), 0);

        // Abort during record 3 word 1
        clear_prev();
        push_rec(0, 1'b0);
        push_rec(1, 1'b0);
        push_rec(2, 1'b0);
        exp_addrs.push_back(16'h000C);
        push_word(32'h0000_0103, 1'b0);
        push_word(32'h9000_00C0, 1'b0);
        do_start(14'd100);
        wait_word(32'h9000_00C0, 100, found);
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        chk("abort_busy", Busy, 1'b0);
        chk("abort_valid", OutValid, 1'b0);
        repeat (6) @(posedge Clk);
        #1;
        chk("abort_no_done", done_cnt, exp_done);
        chk("abort_words_left", exp_words.size(), 0);
        chk("abort_addrs_left", exp_addrs.size(), 0);
        clear_prev();
        push_rec(0, 1'b1);
        do_start(14'd1);
        wait_done(50);
        exp_done++;
        chk("after_abort_done_count", done_cnt, exp_done);

        // Asynchronous reset mid-stream
        clear_prev();
        push_rec(0, 1'b0);
        push_rec(1, 1'b1);
        do_start(14'd2);
        wait_word(32'h0000_0305, 50, found);
        Rst = 1'b1;
        #1;
        chk_outputs_zero("async_rst");
        exp_words.delete();
        exp_addrs.delete();
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        chk("rst_no_done", done_cnt, exp_done);
        chk("rst_idle_busy", Busy, 1'b0);

        // Clamp to full capacity
        clear_prev();
        for (int i = 0; i < 12288; i++) push_rec(i, i == 12287);
        rec_cnt = 0;
        do_start(14'h3FFF);
        wait_done(70000);
        exp_done++;
        chk("clamp_records", rec_cnt, 12288);
        chk("clamp_last_addr", last_addr, 16'hBFFC);
        chk("clamp_done_count", done_cnt, exp_done);
        chk("clamp_words_left", exp_words.size(), 0);

`ifdef AXI_BRAM_LOG_READER_TSDELTA_EN
        // Timestamp deltas including a wrap
        mem[0][95:64] = 32'h10;
        mem[1][95:64] = 32'h25;
        mem[2][95:64] = 32'h05;
        exp_addrs.push_back(16'h0);
        exp_addrs.push_back(16'h4);
        exp_addrs.push_back(16'h8);
        push_word(32'h0000_0305, 1'b0);
        push_word(32'h8000_0000, 1'b0);
        push_word(32'h0000_0010, 1'b0);
        push_word(32'h0000_0006, 1'b0);
        push_word(32'h8000_0040, 1'b0);
        push_word(32'h0000_0015, 1'b0);
        push_word(32'h0000_0102, 1'b0);
        push_word(32'h9000_0080, 1'b0);
        push_word(32'hFFFF_FFE0, 1'b1);
        do_start(14'd3);
        wait_done(50);
        exp_done++;
        chk("tsd_done_count", done_cnt, exp_done);
        chk("tsd_words_left", exp_words.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
